// File: rtl/fadd_pkg.sv
// Shared definitions for the float-add normalize/round back end:
// format constants, flag bit positions and the S1-to-S2 stage record.
package fadd_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    // Bit positions inside out_flags = {overflow, underflow, inexact}
    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_INX = 0;

    typedef struct packed {
        logic        sign;
        logic [8:0]  exp;
        logic [23:0] mant;
        logic        g;
        logic        r;
        logic        s;
        logic        inf;
        logic        nan;
    } s1_t;

endpackage

// File: rtl/fadd_lzc24.sv
// Combinational leading-zero counter over 24 bits; all-zero input yields 24.
module fadd_lzc24 (
    input  logic [23:0] vec,
    output logic [4:0]  count
);

    // Scanning upward lets the highest set bit win the final assignment.
    always_comb begin
        count = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (vec[i]) begin
                count = 5'(23 - i);
            end
        end
    end

endmodule

// File: rtl/fadd_norm_round.sv
// Two-stage normalize (S1) and round-to-nearest-even/pack (S2) pipeline
// for a single-precision adder, with valid/ready flow control.
module fadd_norm_round
    import fadd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [24:0] in_sum,
    input  logic [2:0]  in_grs,
    input  logic        in_inf,
    input  logic        in_nan,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [2:0]  out_flags
);

    logic             s1_valid;
    logic             s2_valid;
    logic             s1_adv;
    logic             s2_adv;
    s1_t              s1_reg;
    s1_t              s1_next;
    logic [4:0]       lz;
    logic [4:0]       sh;
    logic [25:0]      vec_sh;

    logic             inc;
    logic [24:0]      mant_r;
    logic [8:0]       exp_r;
    logic [MAN_W-1:0] frac;
    logic             inexact;
    logic [31:0]      result_next;
    logic [2:0]       flags_next;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    fadd_lzc24 u_lzc (
        .vec   (in_sum[23:0]),
        .count (lz)
    );

    // S1: normalize
    always_comb begin
        s1_next      = '0;
        sh           = '0;
        vec_sh       = '0;
        s1_next.sign = in_sign;
        s1_next.inf  = in_inf;
        s1_next.nan  = in_nan;
        if (in_sum[24]) begin
            s1_next.mant = in_sum[24:1];
            s1_next.g    = in_sum[0];
            s1_next.r    = in_grs[2];
            s1_next.s    = in_grs[1] | in_grs[0];
            s1_next.exp  = {1'b0, in_exp} + 9'd1;
        end else if (in_sum == '0 && in_grs == '0) begin
            // Exact zero is forced to +0; the sign only survives for infinities.
            s1_next.sign = in_inf & in_sign;
        end else begin
            if ({3'b000, lz} < in_exp) begin
                sh          = lz;
                s1_next.exp = {1'b0, in_exp} - {4'b0000, lz};
            end else begin
                sh          = (in_exp == 8'd0) ? 5'd0 : in_exp[4:0] - 5'd1;
                s1_next.exp = '0;
            end
            vec_sh       = {in_sum[23:0], in_grs[2], in_grs[1]} << sh;
            s1_next.mant = vec_sh[25:2];
            s1_next.g    = vec_sh[1];
            s1_next.r    = vec_sh[0];
            s1_next.s    = in_grs[0];
        end
    end

    // S2: round to nearest even and pack
    always_comb begin
        inc     = s1_reg.g & (s1_reg.r | s1_reg.s | s1_reg.mant[0]);
        mant_r  = {1'b0, s1_reg.mant} + {24'd0, inc};
        exp_r   = s1_reg.exp;
        frac    = mant_r[22:0];
        inexact = s1_reg.g | s1_reg.r | s1_reg.s;
        if (mant_r[24]) begin
            exp_r = s1_reg.exp + 9'd1;
            frac  = mant_r[23:1];
        end else if (s1_reg.exp == 9'd0 && mant_r[23]) begin
            // Subnormal rounded up into the smallest normal.
            exp_r = 9'd1;
        end
        result_next           = {s1_reg.sign, exp_r[7:0], frac};
        flags_next            = '0;
        flags_next[FLAG_UNF]  = (exp_r == 9'd0) & inexact;
        flags_next[FLAG_INX]  = inexact;
        if (s1_reg.nan) begin
            result_next = QNAN;
            flags_next  = '0;
        end else if (s1_reg.inf) begin
            result_next = {s1_reg.sign, 8'hFF, 23'd0};
            flags_next  = '0;
        end else if (exp_r >= 9'd255) begin
            result_next          = {s1_reg.sign, 8'hFF, 23'd0};
            flags_next           = '0;
            flags_next[FLAG_OVF] = 1'b1;
            flags_next[FLAG_INX] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            s1_reg <= s1_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            out_result <= 32'h0;
            out_flags  <= 3'b000;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= result_next;
                out_flags  <= flags_next;
            end
        end
    end

endmodule

// File: doc/fadd_norm_round.md
FADD_NORM_ROUND -- requirements
Module: fadd_norm_round

Interface
REQ-001 Parameters: none; all widths are fixed by the single-precision format.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  raw adder result presented.
REQ-006 in_ready  out  1  stage accepts the input this cycle.
REQ-007 in_sign  in  1  result sign from the aligned-add stage.
REQ-008 in_exp  in  8  exponent of the larger operand, biased; range 1..254 for finite inputs.
REQ-009 in_sum  in  25  raw magnitude sum; bit24 = carry-out, bit23 = hidden-bit position.
REQ-010 in_grs  in  3  guard, round and sticky bits shifted out during alignment.
REQ-011 in_inf  in  1  an operand was infinite (takes priority over the sum).
REQ-012 in_nan  in  1  an operand was NaN, or the operation was inf minus inf (highest priority).
REQ-013 out_valid  out  1  out_result is valid.
REQ-014 out_ready  in  1  consumer accepts the result.
REQ-015 out_result  out  32  IEEE-754 single-precision result.
REQ-016 out_flags  out  3  {overflow, underflow, inexact}.

Function
REQ-017 Pipeline shall have two registered stages: S1 normalizes (LZC plus shift); S2 rounds and packs. Latency is 2 cycles from accepted input to out_valid when there is no stall.
REQ-018 Handshakes: transfer occurs when valid and ready are both high.
- S2 advances when !s2_valid or out_ready.
- S1 advances when !s1_valid or S2 advances.
- in_ready equals the S1-advance term, combinationally.
- Full throughput is 1 result per cycle; a stall holds all stage contents unchanged.
REQ-019 Carry case (in_sum[24]=1): shift the sum right by 1 and increment the exponent. New guard = sum[0], new round = grs[2], new sticky = grs[1] | grs[0].
REQ-020 No-carry case: lz = leading zeros of in_sum[23:0].
- If lz < in_exp: shift left by lz and set exp = in_exp - lz.
- Otherwise (subnormal): shift left by in_exp - 1 and set exp = 0.
- Left shifts shift the G, then R bits into the LSBs; sticky is retained.
REQ-021 Zero case: in_sum = 0 and in_grs = 0 shall produce +0 (0x00000000) with no flags set.
REQ-022 Rounding shall be round-to-nearest-even: increment when G & (R | S | LSB). A mantissa carry out of rounding increments the exponent; rounding up from a subnormal to 1.0x sets exp = 1.
REQ-023 Overflow: a final exp >= 255 shall produce {sign, 8'hFF, 23'b0} with overflow = 1 and inexact = 1.
REQ-024 Flag definitions:
- inexact = G | R | S after normalization.
- underflow = (result is subnormal or zero) & inexact.
REQ-025 NaN inputs shall produce 0x7FC00000. Inf inputs shall produce {in_sign, 8'hFF, 23'b0}. Both cases set all flags to 0.
REQ-026 Results shall leave in acceptance order, with no loss and no duplication under any out_ready pattern.

Reset
REQ-027 While rst is high: s1_valid = s2_valid = out_valid = 0, out_result = 32'h0, out_flags = 3'b0. Datapath registers need no reset.
REQ-028 Reset asserted mid-operation shall discard all in-flight results immediately. The first valid output after deassertion comes 2 cycles after the first accepted input.

Structure
REQ-029 The shared package fadd_pkg shall hold:
- Constants: EXP_W = 8, MAN_W = 23, BIAS = 127, QNAN = 32'h7FC00000.
- The flag-index constants.
- The S1-to-S2 packed struct typedef {sign, exp[8:0], mant[23:0], g, r, s, inf, nan}.
REQ-030 One sub-module, fadd_lzc24, shall be combinational: it counts leading zeros of a 24-bit vector and outputs 5 bits, with 24 for all-zero.

Verification
REQ-031 1.0 + 1.0: in_exp = 127, in_sum = 25'h1000000, grs = 0 -> out_result = 0x40000000, flags = 000, exactly 2 cycles later.
REQ-032 Cancellation: in_exp = 130, in_sum = 25'h0000001, grs = 0 -> 0x35800000, flags = 000.
REQ-033 Ties:
- in_exp = 127, in_sum = 25'h0800001, grs = 100 -> 0x3F800002, inexact.
- in_sum = 25'h0800000, grs = 100 -> 0x3F800000, inexact.
REQ-034 Overflow: in_exp = 254, in_sum = 25'h1FFFFFF, grs = 111 -> 0x7F800000, flags = 101. Then in_nan = 1 -> 0x7FC00000, flags = 000.
REQ-035 Backpressure: 4 back-to-back inputs with out_ready low for cycles 1-5.
- in_ready drops after 2 inputs are held.
- After out_ready rises, 4 results emerge in order with no gaps or duplicates.
REQ-036 Reset mid-flight: assert rst while s1_valid = s2_valid = 1 -> out_valid = 0 asynchronously; no stale result appears after release.
